// File: rtl/seq_detector_param.sv
// Purpose : parametrised serial pattern detector, Mealy flag y plus registered copy y_q and a saturating match counter.
// Latency : y is combinational (0 cycles); y_q and match_count reflect a match after the next rising edge.
// Backpres: none; en qualifies each input bit, and cycles with en=0 are skipped without disturbing the history.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   x           - serial data bit
//   en          - bit-valid qualifier; x is consumed only when en=1
//   clr         - synchronous clear of match_count (wins over a same-edge match)
//   y           - combinational match: the current x completes the pattern
//   y_q         - y registered one cycle later
//   match_count - matches since reset/clr, saturating at all-ones
module seq_detector_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_count
);

    generate
        if (LEN < 2 || LEN > 32) begin : g_len_check
            $error("seq_detector_param: LEN must lie in 2..32");
        end
    endgenerate

    // fill counts valid history bits 0..LEN-1; $clog2(LEN) bits are enough
    localparam int               FW        = $clog2(LEN);
    localparam logic [FW-1:0]    FILL_FULL = FW'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [LEN-2:0] hist;     // last LEN-1 consumed bits, newest in bit 0
    logic [FW-1:0]  fill;
    logic [LEN-1:0] window;   // history with the live bit appended

    assign window = {hist, x};

    // A match needs a full history; fill==0 after reset keeps y low during reset.
    assign y = en && (fill == FILL_FULL) && (window == PATTERN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist        <= '0;
            fill        <= '0;
            y_q         <= 1'b0;
            match_count <= '0;
        end else begin
            // y is 0 whenever en=0, so y_q naturally drops in skipped cycles
            y_q <= y;

            if (en) begin
                hist <= window[LEN-2:0];
                // Non-overlapping mode forgets the matched bits; the stale
                // hist content is masked by fill until it is refilled.
                if (!OVERLAP && y) begin
                    fill <= '0;
                end else if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end

            if (clr) begin
                match_count <= '0;
            end else if (y && (match_count != CNT_MAX)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0] x_a = '0;
    logic [NI-1:0] en_a = '0;
    logic [NI-1:0] clr_a = '0;
    logic [NI-1:0] y_o;
    logic [NI-1:0] yq_o;
    logic [7:0] c0, c1, c3, c4;
    logic [1:0] c2;
    int cnt_o [NI];

    always #5 clk = ~clk;

    // 0: defaults, 1: non-overlapping, 2: LEN=2 counter width 2, 3/4: LEN=8 A5 non-overlap/overlap
    seq_detector_param u0 (.clk(clk), .reset(rst_n), .x(x_a[0]), .en(en_a[0]), .clr(clr_a[0]),
                           .y(y_o[0]), .y_q(yq_o[0]), .match_count(c0));
    seq_detector_param #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .reset(rst_n), .x(x_a[1]), .en(en_a[1]), .clr(clr_a[1]),
        .y(y_o[1]), .y_q(yq_o[1]), .match_count(c1));
    seq_detector_param #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .reset(rst_n), .x(x_a[2]), .en(en_a[2]), .clr(clr_a[2]),
        .y(y_o[2]), .y_q(yq_o[2]), .match_count(c2));
    seq_detector_param #(.LEN(8), .PATTERN(8'hA5), .OVERLAP(1'b0), .CNT_W(8)) u3 (
        .clk(clk), .reset(rst_n), .x(x_a[3]), .en(en_a[3]), .clr(clr_a[3]),
        .y(y_o[3]), .y_q(yq_o[3]), .match_count(c3));
    seq_detector_param #(.LEN(8), .PATTERN(8'hA5), .OVERLAP(1'b1), .CNT_W(8)) u4 (
        .clk(clk), .reset(rst_n), .x(x_a[4]), .en(en_a[4]), .clr(clr_a[4]),
        .y(y_o[4]), .y_q(yq_o[4]), .match_count(c4));

    assign cnt_o[0] = {24'd0, c0};
    assign cnt_o[1] = {24'd0, c1};
    assign cnt_o[2] = {30'd0, c2};
    assign cnt_o[3] = {24'd0, c3};
    assign cnt_o[4] = {24'd0, c4};

    // Reference model configuration
    int       m_len [NI] = '{4, 4, 2, 8, 8};
    bit [31:0] m_pat [NI] = '{32'hD, 32'hD, 32'h3, 32'hA5, 32'hA5};
    bit       m_ovl [NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int       m_max [NI] = '{255, 255, 3, 255, 255};

    // Reference model state: consumed bits since reset / last discarding match
    bit hq [NI][$];
    int m_cnt [NI];
    bit m_yq [NI];

    typedef struct {
        int inst;
        int cyc;
        bit y;
        bit yq;
        int cnt;
    } exp_t;
    exp_t sb [$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input int inst, input int c, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d step%0d: got %0d, expected %0d", name, inst, c, act, exp);
        end
    endtask

    // Pattern matches when the last LEN-1 consumed bits followed by x spell PATTERN (MSB first)
    function automatic bit model_match(input int i, input bit xv);
        int L = m_len[i];
        int n = hq[i].size();
        if (n < L - 1) return 1'b0;
        for (int k = 0; k < L - 1; k++) begin
            if (hq[i][n - (L - 1) + k] != m_pat[i][L - 1 - k]) return 1'b0;
        end
        return xv == m_pat[i][0];
    endfunction

    // Drive one cycle: instances in mask get (xv, ev, cv), others are idle with random x
    task automatic step(input bit [NI-1:0] mask, input bit xv, input bit ev, input bit cv, input bit rv);
        bit m [NI];
        @(negedge clk);
        cyc++;
        rst_n = rv;
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                x_a[i] = xv; en_a[i] = ev; clr_a[i] = cv;
            end else begin
                x_a[i] = 1'($urandom); en_a[i] = 1'b0; clr_a[i] = 1'b0;
            end
        end
        if (!rv) begin
            for (int i = 0; i < NI; i++) begin
                hq[i].delete(); m_cnt[i] = 0; m_yq[i] = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            m[i] = mask[i] && rv && ev && model_match(i, xv);
            if (mask[i]) sb.push_back('{i, cyc, m[i], m_yq[i], m_cnt[i]});
        end
        if (rv) begin
            for (int i = 0; i < NI; i++) begin
                m_yq[i] = m[i];
                if (mask[i] && cv) m_cnt[i] = 0;
                else if (m[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
                if (mask[i] && ev) begin
                    if (m[i] && !m_ovl[i]) hq[i].delete();
                    else begin
                        hq[i].push_back(xv);
                        if (hq[i].size() > 40) void'(hq[i].pop_front());
                    end
                end
            end
        end
    endtask

    task automatic idle_reset(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare everything the driver queued for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("y", e.inst, e.cyc, int'(y_o[e.inst]), int'(e.y));
                chk("y_q", e.inst, e.cyc, int'(yq_o[e.inst]), int'(e.yq));
                chk("match_count", e.inst, e.cyc, cnt_o[e.inst], e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit stream [1000];

    initial begin
        bit [7:0] pat8;
        int pos;
        bit s1 [9];
        s1 = '{1,0,1,1,0,1,1,0,1};

        // Reset state of all instances
        step('1, 1'b1, 1'b1, 1'b0, 1'b0);
        step('1, 1'b0, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Default stream, overlap (inst0) and non-overlap (inst1)
        foreach (s1[k]) step(5'b00011, s1[k], 1'b1, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("ovl_count", 0, cyc, cnt_o[0], 2);
        chk("novl_count", 1, cyc, cnt_o[1], 1);

        // 1101 with en=0 gaps carrying random x
        idle_reset(2);
        s1 = '{1,1,0,1,0,0,0,0,0};
        for (int k = 0; k < 4; k++) begin
            step(5'b00001, s1[k], 1'b1, 1'b0, 1'b1);
            step(5'b00001, 1'($urandom), 1'b0, 1'b0, 1'b1);
            step(5'b00001, 1'($urandom), 1'b0, 1'b0, 1'b1);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("gap_count", 0, cyc, cnt_o[0], 1);

        // Saturation with CNT_W=2, then clr on a matching edge
        idle_reset(1);
        for (int k = 0; k < 11; k++) step(5'b00100, 1'b1, 1'b1, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("sat_count", 2, cyc, cnt_o[2], 3);
        step(5'b00100, 1'b1, 1'b1, 1'b1, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("clr_count", 2, cyc, cnt_o[2], 0);

        // Reset in the middle of 1,1,0
        idle_reset(1);
        step(5'b00001, 1'b1, 1'b1, 1'b0, 1'b1);
        step(5'b00001, 1'b1, 1'b1, 1'b0, 1'b1);
        step(5'b00001, 1'b0, 1'b1, 1'b0, 1'b0);
        step(5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'b00001, 1'b1, 1'b1, 1'b0, 1'b1);
        s1 = '{1,1,0,1,0,0,0,0,0};
        for (int k = 0; k < 4; k++) step(5'b00001, s1[k], 1'b1, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("post_reset_count", 0, cyc, cnt_o[0], 1);

        // Random 1000-bit stream with injected A5 bursts, both overlap modes
        pat8 = 8'hA5;
        pos = 0;
        while (pos < 1000) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int b = 7; b >= 0 && pos < 1000; b--) begin
                    stream[pos] = pat8[b]; pos++;
                end
            end else begin
                stream[pos] = 1'($urandom); pos++;
            end
        end
        idle_reset(1);
        pos = 0;
        while (pos < 1000) begin
            if ($urandom_range(0, 4) == 0) begin
                step(5'b11000, 1'($urandom), 1'b0, 1'($urandom_range(0, 39) == 0), 1'b1);
            end else begin
                step(5'b11000, stream[pos], 1'b1, 1'($urandom_range(0, 39) == 0), 1'b1);
                pos++;
            end
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 0, cyc, sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
